// File: rtl/cam_config_sequencer.sv
// Camera register-configuration sequencer: walks a {reg, value} ROM and issues
// each entry as an SCCB write, with delay markers, end marker and optional read-back.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FETCH  | rom_addr presented to the ROM
// FWAIT  | ROM registered latency
// DECODE | classify the ROM word (end / delay / register write)
// DELAY  | scaled delay countdown
// WREQ   | waiting for sccb_ready to issue the write
// WWAIT  | write in flight
// RREQ   | waiting for sccb_ready to issue the read-back
// RWAIT  | read-back in flight
// CHECK  | compare read-back data against the written value
// NEXT   | advance to the next ROM entry
// DONE   | sequence completed, holds until start
// ERROR  | retry budget exhausted, holds until start
module cam_config_sequencer #(
  parameter int ROM_AW       = 8,
  parameter int DELAY_CYCLES = 500000,
  parameter int DELAY_W      = 24,
  parameter int MAX_RETRY    = 3,
  parameter int VERIFY       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              sccb_ready,
  output logic              sccb_start,
  output logic              sccb_rw,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_wdata,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  input  logic [7:0]        sccb_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_addr
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_FWAIT  = 4'd2;
  localparam logic [3:0] S_DECODE = 4'd3;
  localparam logic [3:0] S_DELAY  = 4'd4;
  localparam logic [3:0] S_WREQ   = 4'd5;
  localparam logic [3:0] S_WWAIT  = 4'd6;
  localparam logic [3:0] S_RREQ   = 4'd7;
  localparam logic [3:0] S_RWAIT  = 4'd8;
  localparam logic [3:0] S_CHECK  = 4'd9;
  localparam logic [3:0] S_NEXT   = 4'd10;
  localparam logic [3:0] S_DONE   = 4'd11;
  localparam logic [3:0] S_ERROR  = 4'd12;

  logic [3:0]         state_q, state_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic               rw_q, rw_d;
  logic [7:0]         reg_q, reg_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [ROM_AW-1:0]  err_addr_q, err_addr_d;
  logic               fail;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    retry_d    = retry_q;
    dly_d      = dly_q;
    rw_d       = rw_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    fail       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          rom_addr_d = '0;
          retry_d    = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (rom_data[15:4] == 12'hFFF) begin
          dly_d   = DELAY_W'(rom_data[3:0] + 5'd1) * DELAY_W'(DELAY_CYCLES);
          state_d = S_DELAY;
        end else begin
          reg_d   = rom_data[15:8];
          wdata_d = rom_data[7:0];
          rw_d    = 1'b0;
          state_d = S_WREQ;
        end
      end
      // Leaves on the cycle the count would reach zero, so DELAY lasts exactly the loaded count.
      S_DELAY: begin
        dly_d = dly_q - DELAY_W'(1);
        if (dly_q == DELAY_W'(1)) state_d = S_NEXT;
      end
      S_WREQ: if (sccb_ready) state_d = S_WWAIT;
      S_WWAIT: begin
        if (sccb_done) begin
          if (sccb_nack) begin
            fail = 1'b1;
          end else if ((VERIFY == 0) || (reg_q == 8'h12 && wdata_q[7])) begin
            state_d = S_NEXT;
          end else begin
            rw_d    = 1'b1;
            state_d = S_RREQ;
          end
        end
      end
      S_RREQ: if (sccb_ready) state_d = S_RWAIT;
      S_RWAIT: begin
        if (sccb_done) begin
          if (sccb_nack) begin
            fail = 1'b1;
          end else begin
            rdata_d = sccb_rdata;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (rdata_q == wdata_q) state_d = S_NEXT;
        else                    fail    = 1'b1;
      end
      S_NEXT: begin
        retry_d = '0;
        if (rom_addr_q == '1) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          rom_addr_d = rom_addr_q + ROM_AW'(1);
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Retries reuse the latched entry; the ROM is not re-read.
    if (fail) begin
      if (retry_q < RETRY_W'(MAX_RETRY)) begin
        retry_d = retry_q + RETRY_W'(1);
        rw_d    = 1'b0;
        state_d = S_WREQ;
      end else begin
        err_addr_d = rom_addr_q;
        error_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_ERROR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      retry_q    <= '0;
      dly_q      <= '0;
      rw_q       <= 1'b0;
      reg_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      retry_q    <= retry_d;
      dly_q      <= dly_d;
      rw_q       <= rw_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  // The request is qualified by sccb_ready so it can only fire when the master accepts it.
  assign sccb_start = sccb_ready && ((state_q == S_WREQ) || (state_q == S_RREQ));
  assign sccb_rw    = rw_q;
  assign sccb_reg   = reg_q;
  assign sccb_wdata = wdata_q;
  assign rom_addr   = rom_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Bench for cam_config_sequencer: directed scenarios plus random ROM programs,
// checked against a transaction-level model of the configuration walk.
module tb_cam_config_sequencer;

  localparam int AW = 3;
  localparam int DC = 10;
  localparam int MR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0;
  logic          sccb_ready = 1'b1;
  logic          sccb_start;
  logic          sccb_rw;
  logic [7:0]    sccb_reg;
  logic [7:0]    sccb_wdata;
  logic          sccb_done = 1'b0;
  logic          sccb_nack = 1'b0;
  logic [7:0]    sccb_rdata = 8'h0;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] err_addr;

  cam_config_sequencer #(
    .ROM_AW(AW), .DELAY_CYCLES(DC), .DELAY_W(12), .MAX_RETRY(MR), .VERIFY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_ready(sccb_ready), .sccb_start(sccb_start), .sccb_rw(sccb_rw),
    .sccb_reg(sccb_reg), .sccb_wdata(sccb_wdata),
    .sccb_done(sccb_done), .sccb_nack(sccb_nack), .sccb_rdata(sccb_rdata),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );

  logic [15:0] rom [8];
  int          nack_cnt [256];
  int          bad_cnt [256];
  logic [7:0]  cam [256];
  logic [16:0] obs [$];
  logic [16:0] expq [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          first_start = -1;
  int          lat = 4;
  bit          spur_en = 1'b0;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SCCB master / camera model: fault counters per register decide nacks and bad read-backs.
  initial begin
    logic [7:0] m_reg;
    logic [7:0] m_wd;
    logic       m_rw;
    int         m_cnt;
    bit         m_busy;
    m_busy = 1'b0;
    m_cnt  = 0;
    m_reg  = 8'h0;
    m_wd   = 8'h0;
    m_rw   = 1'b0;
    forever begin
      @(negedge clk);
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      if (!rst_n) begin
        m_busy     = 1'b0;
        sccb_ready = 1'b1;
      end else if (m_busy) begin
        sccb_ready = 1'b0;
        if (m_cnt > 1) begin
          m_cnt--;
        end else begin
          chk("hold_rw", 32'(sccb_rw), 32'(m_rw));
          chk("hold_reg", 32'(sccb_reg), 32'(m_reg));
          chk("hold_wdata", 32'(sccb_wdata), 32'(m_wd));
          sccb_done  = 1'b1;
          sccb_rdata = 8'($urandom);
          if (nack_cnt[m_reg] > 0) begin
            sccb_nack = 1'b1;
            nack_cnt[m_reg]--;
          end else if (!m_rw) begin
            cam[m_reg] = m_wd;
          end else if (bad_cnt[m_reg] > 0) begin
            sccb_rdata = cam[m_reg] ^ 8'h5A;
            bad_cnt[m_reg]--;
          end else begin
            sccb_rdata = cam[m_reg];
          end
          m_busy     = 1'b0;
          sccb_ready = 1'b1;
        end
      end else if (sccb_start) begin
        chk("start_ready", 32'(sccb_ready), 32'd1);
        obs.push_back({sccb_rw, sccb_reg, sccb_wdata});
        if (first_start < 0) first_start = cyc - t0;
        m_rw   = sccb_rw;
        m_reg  = sccb_reg;
        m_wd   = sccb_wdata;
        m_busy = 1'b1;
        m_cnt  = lat;
      end else if (spur_en && $urandom_range(7) == 0) begin
        sccb_done  = 1'b1;
        sccb_nack  = 1'($urandom);
        sccb_rdata = 8'($urandom);
      end
    end
  end

  // Expected transaction list and outcome, walking the ROM entry by entry.
  task automatic model(output int e_done, output int e_err, output int e_addr);
    int nk [256];
    int bd [256];
    int a;
    int r;
    logic [15:0] w;
    bit ok;
    bit fin;
    nk = nack_cnt;
    bd = bad_cnt;
    expq.delete();
    a = 0; e_done = 0; e_err = 0; fin = 1'b0;
    while (!fin) begin
      w = rom[a];
      if (w == 16'hFFFF) begin
        e_done = 1;
        fin    = 1'b1;
      end else if (w < 16'hFFF0) begin
        r = 0;
        forever begin
          ok = 1'b0;
          expq.push_back({1'b0, w});
          if (nk[w[15:8]] > 0) nk[w[15:8]]--;
          else if (w[15:8] == 8'h12 && w[7]) ok = 1'b1;
          else begin
            expq.push_back({1'b1, w});
            if (nk[w[15:8]] > 0) nk[w[15:8]]--;
            else if (bd[w[15:8]] > 0) bd[w[15:8]]--;
            else ok = 1'b1;
          end
          if (ok) break;
          if (r < MR) r++;
          else begin
            e_err = 1;
            fin   = 1'b1;
            break;
          end
        end
      end
      if (!fin) begin
        if (a == 7) begin
          e_done = 1;
          fin    = 1'b1;
        end else a++;
      end
    end
    e_addr = a;
  endtask

  task automatic clr_faults();
    for (int i = 0; i < 256; i++) begin
      nack_cnt[i] = 0;
      bad_cnt[i]  = 0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ":state_out"}, {28'd0, sccb_start, sccb_rw, busy, done}, 32'd0);
    chk({tag, ":error"}, 32'(error), 32'd0);
    chk({tag, ":rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, ":err_addr"}, 32'(err_addr), 32'd0);
    chk({tag, ":reg_wdata"}, {16'd0, sccb_reg, sccb_wdata}, 32'd0);
  endtask

  task automatic run_seq(input string tag, input int busy_pulse);
    int ed, ee, ea;
    bit fin;
    model(ed, ee, ea);
    obs.delete();
    first_start = -1;
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, ":done_cleared"}, {30'd0, done, error}, 32'd0);
    chk({tag, ":addr_after_start"}, 32'(rom_addr), 32'd0);
    fin = 1'b0;
    for (int i = 0; i < 4000 && !fin; i++) begin
      @(negedge clk);
      if (done || error) fin = 1'b1;
      start = (!fin && i == busy_pulse);
      if (start) chk({tag, ":busy_at_pulse"}, 32'(busy), 32'd1);
    end
    start = 1'b0;
    chk({tag, ":finished"}, 32'(done | error), 32'd1);
    chk({tag, ":done"}, 32'(done), 32'(ed));
    chk({tag, ":error"}, 32'(error), 32'(ee));
    chk({tag, ":busy_end"}, 32'(busy), 32'd0);
    chk({tag, ":final_addr"}, 32'(rom_addr), 32'(ea));
    if (ee != 0) chk({tag, ":err_addr"}, 32'(err_addr), 32'(ea));
    chk({tag, ":txn_count"}, 32'(obs.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < obs.size(); i++)
      chk($sformatf("%s:txn%0d", tag, i), 32'(obs[i]), 32'(expq[i]));
  endtask

  initial begin
    int wr40;
    int ws;
    logic [7:0] rg;
    clr_faults();
    for (int i = 0; i < 256; i++) cam[i] = 8'h0;
    for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;

    repeat (3) @(negedge clk);
    #1 chk_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    rom[0] = 16'h1280; rom[1] = 16'h1180; rom[2] = 16'hFFFF;
    run_seq("basic", -1);

    rom[0] = 16'hFFF0; rom[1] = 16'hFFF3; rom[2] = 16'h3A04; rom[3] = 16'hFFFF;
    run_seq("delay", -1);
    chk("delay:first_sccb_cycle", 32'(first_start), 32'(3 + (DC + 4) + (4 * DC + 4) + 1));

    for (int i = 0; i < 8; i++) rom[i] = {8'(8'h20 + i), 8'($urandom)};
    nack_cnt[8'h25] = 100;
    run_seq("retry", -1);
    ws = 0;
    foreach (obs[i]) if (obs[i][15:8] == 8'h25) ws++;
    chk("retry:attempts_entry5", 32'(ws), 32'(MR + 1));
    clr_faults();

    lat = 6;
    obs.delete();
    first_start = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && first_start < 0; i++) @(negedge clk);
    chk("rst_mid:reached_wwait", 32'(first_start >= 0), 32'd1);
    rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat   = 4;

    rom[0] = 16'h1280; rom[1] = 16'h40D0; rom[2] = 16'hFFFF;
    bad_cnt[8'h40] = 1;
    run_seq("verify", -1);
    wr40 = 0;
    foreach (obs[i]) if (obs[i][16] == 1'b0 && obs[i][15:8] == 8'h40) wr40++;
    chk("verify:writes_of_40", 32'(wr40), 32'd2);
    clr_faults();

    for (int i = 0; i < 8; i++) rom[i] = {8'(8'h50 + i), 8'($urandom)};
    run_seq("no_end", 5);
    run_seq("restart", -1);

    spur_en = 1'b1;
    for (int t = 0; t < 25; t++) begin
      clr_faults();
      lat = $urandom_range(5, 1);
      for (int i = 0; i < 8; i++) begin
        ws = $urandom_range(99);
        if (ws < 8) rom[i] = 16'hFFFF;
        else if (ws < 20) rom[i] = 16'hFFF0 | 16'($urandom_range(2));
        else begin
          rg = ($urandom_range(5) == 0) ? 8'h12 : 8'(8'h30 + $urandom_range(5));
          rom[i] = {rg, 8'($urandom)};
        end
      end
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(2) == 0) nack_cnt[8'h30 + k] = $urandom_range(3);
        if ($urandom_range(2) == 0) bad_cnt[8'h30 + k] = $urandom_range(3);
      end
      if ($urandom_range(3) == 0) nack_cnt[8'h12] = $urandom_range(3);
      run_seq($sformatf("rand%0d", t), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
